// File: rtl/spi_sample_transmitter.sv
// spi_sample_transmitter: SPI master that frames 16-bit frequency/amplitude words for the sample link.
// Define SPI_TX_DEDUP_EN to drop a word equal to the last one sent of its type.
module spi_sample_transmitter #(
  parameter int CLK_DIV    = 25,
  parameter int GAP_CYCLES = 50
) (
  input  logic        CLK_50Mhz,
  input  logic        reset_n,
  input  logic        freq_valid,
  input  logic [12:0] freq_data,
  output logic        freq_ready,
  input  logic        amp_valid,
  input  logic [7:0]  amp_data,
  output logic        amp_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        output_SPI_SCLK,
  output logic        output_SPI_CS_n,
  output logic        output_SPI_SDO
);
  localparam int CMAX = (2 * CLK_DIV > GAP_CYCLES) ? 2 * CLK_DIV : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HALF     = CW'(CLK_DIV);
  localparam logic [CW-1:0] PER_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, COMMIT, GAP} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] word_q, word_d;
  logic [12:0] freq_q, freq_d;
  logic [7:0]  amp_q, amp_d;
  logic        freq_pend_q, freq_pend_d;
  logic        amp_pend_q, amp_pend_d;
  logic        last_amp_q, last_amp_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        sdo_q, sdo_d;
  logic        done_q, done_d;
  logic        pick_amp, try_launch, launch, drop, wrap, freq_acc, amp_acc;

  assign freq_ready      = !freq_pend_q;
  assign amp_ready       = !amp_pend_q;
  assign busy            = state_q != IDLE;
  assign frame_done      = done_q;
  assign output_SPI_SCLK = sclk_q;
  assign output_SPI_CS_n = cs_n_q;
  assign output_SPI_SDO  = sdo_q;

  // With both pending, alternate away from the type sent last.
  assign pick_amp   = amp_pend_q && (!freq_pend_q || !last_amp_q);
  assign try_launch = state_q == IDLE && (freq_pend_q || amp_pend_q);
  assign launch     = try_launch && !drop;
  assign freq_acc   = freq_valid && !freq_pend_q;
  assign amp_acc    = amp_valid && !amp_pend_q;

`ifdef SPI_TX_DEDUP_EN
  logic [12:0] freq_sent_q;
  logic [7:0]  amp_sent_q;
  logic        freq_sent_vld_q, amp_sent_vld_q;

  assign drop = pick_amp ? (amp_sent_vld_q && amp_sent_q == amp_q)
                         : (freq_sent_vld_q && freq_sent_q == freq_q);

  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      freq_sent_q     <= '0;
      amp_sent_q      <= '0;
      freq_sent_vld_q <= 1'b0;
      amp_sent_vld_q  <= 1'b0;
    end else if (launch) begin
      if (pick_amp) begin
        amp_sent_q     <= amp_q;
        amp_sent_vld_q <= 1'b1;
      end else begin
        freq_sent_q     <= freq_q;
        freq_sent_vld_q <= 1'b1;
      end
    end
  end
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    freq_pend_d = freq_acc || (freq_pend_q && !(try_launch && !pick_amp));
    amp_pend_d  = amp_acc || (amp_pend_q && !(try_launch && pick_amp));
    freq_d      = freq_acc ? freq_data : freq_q;
    amp_d       = amp_acc ? amp_data : amp_q;
    last_amp_d  = launch ? pick_amp : last_amp_q;
    word_d      = launch ? (pick_amp ? {3'b001, 5'b0, amp_q} : {3'b000, freq_q}) : word_q;
  end

  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      word_q      <= '0;
      freq_q      <= '0;
      amp_q       <= '0;
      freq_pend_q <= 1'b0;
      amp_pend_q  <= 1'b0;
      last_amp_q  <= 1'b1;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sdo_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      word_q      <= word_d;
      freq_q      <= freq_d;
      amp_q       <= amp_d;
      freq_pend_q <= freq_pend_d;
      amp_pend_q  <= amp_pend_d;
      last_amp_q  <= last_amp_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      sdo_q       <= sdo_d;
      done_q      <= done_d;
    end
  end

  // The counter spans one SCLK period in the clocked states and the gap length in GAP.
  always_comb begin
    wrap    = state_q != GAP && cnt_q == PER_LAST;
    state_d = state_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE:    if (launch) state_d = LEAD;
      LEAD:    if (wrap) begin
        state_d = SHIFT;
        bit_d   = '0;
      end
      SHIFT:   if (wrap) begin
        bit_d   = bit_q + 4'd1;
        state_d = bit_q == 4'd15 ? COMMIT : SHIFT;
      end
      COMMIT:  if (wrap) state_d = GAP;
      GAP:     if (cnt_q == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_q == IDLE || state_d != state_q || wrap) ? '0 : cnt_q + 1'b1;
  end

  // Outputs are registered from next-state so the pins are glitch-free and aligned with state_q.
  always_comb begin
    sclk_d = (state_d == LEAD || state_d == SHIFT || state_d == COMMIT) && cnt_d >= HALF;
    cs_n_d = !(state_d == SHIFT || state_d == COMMIT);
    sdo_d  = state_d == SHIFT && word_q[~bit_d];
    done_d = state_d == COMMIT && cnt_d == PER_LAST;
  end
endmodule

// File: tb/tb_spi_sample_transmitter.sv
// tb_spi_sample_transmitter: directed vectors and corner sequences for spi_sample_transmitter (CLK_DIV=2, GAP_CYCLES=4).
module tb_spi_sample_transmitter;
  logic clk = 1'b0, reset_n = 1'b0;
  logic freq_valid = 1'b0, amp_valid = 1'b0;
  logic [12:0] freq_data = '0;
  logic [7:0] amp_data = '0;
  logic freq_ready, amp_ready, busy, frame_done, sclk, cs_n, sdo;

  spi_sample_transmitter #(.CLK_DIV(2), .GAP_CYCLES(4)) dut (
    .CLK_50Mhz(clk), .reset_n(reset_n),
    .freq_valid(freq_valid), .freq_data(freq_data), .freq_ready(freq_ready),
    .amp_valid(amp_valid), .amp_data(amp_data), .amp_ready(amp_ready),
    .busy(busy), .frame_done(frame_done),
    .output_SPI_SCLK(sclk), .output_SPI_CS_n(cs_n), .output_SPI_SDO(sdo)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, rises = 0, low_rises = 0, viol = 0;
  int t_b = 0, t_cf = 0, t_cr = 0, t_d = 0, t_bf = 0, last_rises = 0, last_low = 0;
  logic [16:0] sr = '0;
  logic [15:0] words[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receiver-side monitor sampled on the falling clock edge.
  initial begin
    logic p_sclk, p_cs, p_busy, p_sdo;
    p_sclk = 0; p_cs = 1; p_busy = 0; p_sdo = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        if (sclk && !p_sclk) begin
          rises++;
          if (!cs_n) begin
            sr = {sr[15:0], sdo};
            low_rises++;
          end
        end
        if (busy && !p_busy) begin t_b = cyc; rises = 0; end
        if (!cs_n && p_cs) begin t_cf = cyc; low_rises = 0; end
        if (cs_n && !p_cs) begin t_cr = cyc; last_low = low_rises; words.push_back(sr[16:1]); end
        if (frame_done) t_d = cyc;
        if (!busy && p_busy) begin t_bf = cyc; last_rises = rises; end
        if (sclk && (cs_n != p_cs || sdo != p_sdo)) viol++;
      end
      p_sclk = sclk; p_cs = cs_n; p_busy = busy; p_sdo = sdo;
    end
  end

  task automatic send(input bit is_amp, input logic [12:0] d);
    int n = 0;
    @(negedge clk);
    if (is_amp) begin amp_valid = 1; amp_data = d[7:0]; end
    else begin freq_valid = 1; freq_data = d; end
    while (!(is_amp ? amp_ready : freq_ready) && n < 1000) begin @(negedge clk); n++; end
    chk("send_timeout", n < 1000, 1);
    @(negedge clk);
    amp_valid = 0; freq_valid = 0;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 200) begin @(negedge clk); n++; end
    chk("busy_rise_timeout", n < 200, 1);
  endtask

  task automatic wait_frames(input int cnt, input int budget);
    int n = 0;
    while ((words.size() < cnt || busy) && n < budget) begin @(negedge clk); n++; end
    chk("frame_timeout", n < budget, 1);
  endtask

  typedef struct { bit is_amp; logic [12:0] d; logic [15:0] exp; } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{0, 13'h0ABC, 16'h0ABC};
    vecs[1] = '{1, 13'h00A5, 16'h20A5};
    vecs[2] = '{0, 13'h1FFF, 16'h1FFF};
    vecs[3] = '{1, 13'h0000, 16'h2000};
    vecs[4] = '{0, 13'h0000, 16'h0000};
    vecs[5] = '{1, 13'h00FF, 16'h20FF};

    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sdo", sdo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_freq_ready", freq_ready, 1);
    chk("rst_amp_ready", amp_ready, 1);
    reset_n = 1;

    // Simultaneous offer after reset: frequency goes first.
    words.delete();
    @(negedge clk);
    freq_valid = 1; freq_data = 13'h0123; amp_valid = 1; amp_data = 8'h5A;
    @(negedge clk);
    freq_valid = 0; amp_valid = 0;
    wait_busy();
    chk("arb_freq_ready", freq_ready, 1);
    chk("arb_amp_ready", amp_ready, 0);
    wait_frames(2, 500);
    chk("arb_first", words.size() > 0 ? words[0] : 16'hxxxx, 16'h0123);
    chk("arb_second", words.size() > 1 ? words[1] : 16'hxxxx, 16'h205A);

    // Back-to-back amplitude words while a frame is in flight.
    words.delete();
    send(1, 13'h0011);
    wait_busy();
    repeat (10) @(negedge clk);
    send(1, 13'h0022);
    @(negedge clk);
    amp_valid = 1; amp_data = 8'h33;
    repeat (5) @(negedge clk);
    chk("stall_amp_ready", amp_ready, 0);
    chk("stall_busy", busy, 1);
    begin
      int n = 0;
      while (!amp_ready && n < 300) begin @(negedge clk); n++; end
      chk("stall_timeout", n < 300, 1);
    end
    chk("stall_release_busy", busy, 1);
    chk("stall_release_frames", words.size(), 1);
    @(negedge clk);
    amp_valid = 0;
    wait_frames(3, 500);
    chk("b2b_w1", words.size() > 1 ? words[1] : 16'hxxxx, 16'h2022);
    chk("b2b_w2", words.size() > 2 ? words[2] : 16'hxxxx, 16'h2033);

    for (int i = 0; i < 6; i++) begin
      words.delete();
      send(vecs[i].is_amp, vecs[i].d);
      wait_busy();
      wait_frames(1, 300);
      chk($sformatf("v%0d_word", i), words.size() > 0 ? words[0] : 16'hxxxx, vecs[i].exp);
      chk($sformatf("v%0d_cs_low_rises", i), last_low, 17);
      chk($sformatf("v%0d_total_rises", i), last_rises, 18);
      chk($sformatf("v%0d_cs_latency", i), t_cf - t_b, 4);
      chk($sformatf("v%0d_done_cycle", i), t_d - t_b + 1, 72);
      chk($sformatf("v%0d_gap", i), t_bf - t_cr, 4);
    end

    // Repeated identical frequency word.
    words.delete();
    send(0, 13'h0100);
    wait_frames(1, 300);
    send(0, 13'h0100);
    repeat (150) @(negedge clk);
`ifdef SPI_TX_DEDUP_EN
    chk("dedup_frames", words.size(), 1);
`else
    chk("dedup_frames", words.size(), 2);
`endif
    chk("dedup_idle", busy, 0);
    chk("dedup_ready", freq_ready, 1);

    // Reset in the middle of SHIFT bit 7.
    words.delete();
    send(0, 13'h0F0F);
    wait_busy();
    send(1, 13'h0044);
    chk("pre_rst_amp_ready", amp_ready, 0);
    begin
      int n = 0;
      while (low_rises < 7 && n < 200) begin @(negedge clk); n++; end
      chk("bit7_timeout", n < 200, 1);
    end
    @(negedge clk);
    #3 reset_n = 0;
    #1;
    chk("abort_sclk", sclk, 0);
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sdo", sdo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_freq_ready", freq_ready, 1);
    chk("abort_amp_ready", amp_ready, 1);
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (100) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_frames", words.size(), 0);

    chk("edge_violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
